// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified fetch/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   localparam int unsigned MAX_D_STREAK_DEFAULT = 4;

   // One-hot grant encoding: bit 0 = fetch, bit 1 = data
   localparam logic [1:0] GNT_NONE  = 2'b00;
   localparam logic [1:0] GNT_FETCH = 2'b01;
   localparam logic [1:0] GNT_DATA  = 2'b10;

endpackage

// File: rtl/arb_prio_sel.sv
// Data-first priority select with a starvation override for fetch.
module arb_prio_sel
   import mem_arb_pkg::*;
(
   input  logic       f_req,
   input  logic       d_req,
   input  logic       streak_full,
   output logic [1:0] gnt
);

   // Fetch wins only when alone or when data has used up its streak allowance
   always_comb begin
      gnt = GNT_NONE;
      if (f_req && (streak_full || !d_req)) begin
         gnt = GNT_FETCH;
      end else if (d_req) begin
         gnt = GNT_DATA;
      end else begin
         gnt = GNT_NONE;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a fetch port and a memory-stage port onto one single-cycle memory.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  f_req,
   input  logic [DATA_WIDTH-1:0] f_addr,
   output logic                  f_gnt,
   output logic                  f_rvalid,
   output logic [DATA_WIDTH-1:0] f_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic                  d_byte,
   input  logic [DATA_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  mem_byte,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stall_f,
   output logic                  stall_m
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);

   logic [1:0]    sel_s;
   logic          f_gnt_s;
   logic          d_gnt_s;
   logic          streak_full_s;
   owner_e        owner_r;
   owner_e        owner_nxt_s;
   logic [SW-1:0] streak_r;
   logic [SW-1:0] streak_nxt_s;

   assign streak_full_s = (streak_r == SW'(MAX_D_STREAK));

   arb_prio_sel u_prio_sel (
      .f_req       (f_req),
      .d_req       (d_req),
      .streak_full (streak_full_s),
      .gnt         (sel_s)
   );

   // Grants are forced low while reset is held so nothing reaches memory
   assign f_gnt_s = rst & sel_s[0];
   assign d_gnt_s = rst & sel_s[1];

   // Next owner of the in-flight read and next data-streak count
   always_comb begin
      owner_nxt_s  = OWN_NONE;
      streak_nxt_s = streak_r;
      if (f_gnt_s) begin
         owner_nxt_s = OWN_FETCH;
      end else if (d_gnt_s && !d_we) begin
         owner_nxt_s = OWN_DATA;
      end else begin
         owner_nxt_s = OWN_NONE;
      end
      if (!f_req || f_gnt_s) begin
         streak_nxt_s = SW'(0);
      end else if (d_gnt_s && !streak_full_s) begin
         streak_nxt_s = streak_r + SW'(1);
      end else begin
         streak_nxt_s = streak_r;
      end
   end

   // Owner and streak registers; reset discards any read in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_r  <= OWN_NONE;
         streak_r <= SW'(0);
      end else begin
         owner_r  <= owner_nxt_s;
         streak_r <= streak_nxt_s;
      end
   end

   assign f_gnt     = f_gnt_s;
   assign d_gnt     = d_gnt_s;
   assign mem_req   = f_gnt_s | d_gnt_s;
   assign mem_we    = d_gnt_s & d_we;
   assign mem_byte  = d_gnt_s & d_byte;
   assign mem_addr  = d_gnt_s ? d_addr : f_addr;
   assign mem_wdata = d_gnt_s ? d_wdata : {DATA_WIDTH{1'b0}};

   assign f_rvalid  = (owner_r == OWN_FETCH);
   assign d_rvalid  = (owner_r == OWN_DATA);
   assign f_rdata   = mem_rdata;
   assign d_rdata   = mem_rdata;

   assign stall_f   = rst & f_req & ~f_gnt_s;
   assign stall_m   = rst & d_req & ~d_gnt_s;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a cycle-level behavioural model.
module tb_unified_mem_arbiter;

   localparam int DW  = 32;
   localparam int MAX = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_byte = 1'b0;
   logic [DW-1:0] f_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, mem_rdata = 32'h0;
   logic          f_gnt, f_rvalid, d_gnt, d_rvalid;
   logic          mem_req, mem_we, mem_byte, stall_f, stall_m;
   logic [DW-1:0] f_rdata, d_rdata, mem_addr, mem_wdata;

   int n_vec = 0;
   int n_err = 0;

   // model state: data grants in a row while fetch waits, and who owns the next response
   int m_streak = 0;
   int m_resp   = 0;   // 0 none, 1 fetch, 2 data

   unified_mem_arbiter #(.DATA_WIDTH(DW), .MAX_D_STREAK(MAX)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall_f(stall_f), .stall_m(stall_m)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare process: every falling edge, outputs against the model
   initial begin
      bit fw, eg_f, eg_d;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("rst_f_gnt", f_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_stall_f", stall_f, 0);
            chk("rst_stall_m", stall_m, 0);
            chk("rst_f_rvalid", f_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            m_streak = 0;
            m_resp   = 0;
         end else begin
            fw   = f_req && (!d_req || m_streak == MAX);
            eg_f = fw;
            eg_d = d_req && !fw;
            chk("f_gnt", f_gnt, eg_f);
            chk("d_gnt", d_gnt, eg_d);
            chk("mem_req", mem_req, eg_f | eg_d);
            chk("mem_we", mem_we, eg_d & d_we);
            chk("mem_byte", mem_byte, eg_d & d_byte);
            if (eg_f) chk("mem_addr_f", mem_addr, f_addr);
            if (eg_d) chk("mem_addr_d", mem_addr, d_addr);
            if (eg_d) chk("mem_wdata", mem_wdata, d_wdata);
            chk("stall_f", stall_f, f_req & !eg_f);
            chk("stall_m", stall_m, d_req & !eg_d);
            chk("f_rvalid", f_rvalid, m_resp == 1);
            chk("d_rvalid", d_rvalid, m_resp == 2);
            if (m_resp == 1) chk("f_rdata", f_rdata, mem_rdata);
            if (m_resp == 2) chk("d_rdata", d_rdata, mem_rdata);
            m_resp = eg_f ? 1 : ((eg_d && !d_we) ? 2 : 0);
            if (!f_req || eg_f) m_streak = 0;
            else if (eg_d && m_streak < MAX) m_streak++;
         end
      end
   end

   // Stimulus: directed scenarios with literal expectations, then random traffic
   initial begin
      logic [9:0] pat;
      bit fg_prev, dg_prev;
      f_req = 1'b1; d_req = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("lit_rst_gnt", {f_gnt, d_gnt}, 2'b00);

      // release with fetch-only request: grant in the very first cycle
      @(posedge clk); #1;
      rst = 1'b1; d_req = 1'b0; f_addr = 32'h100;
      @(negedge clk);
      chk("lit_fetch_gnt", f_gnt, 1);
      chk("lit_fetch_addr", mem_addr, 32'h100);
      chk("lit_fetch_stall", stall_f, 0);
      step();
      f_req = 1'b0; mem_rdata = 32'hCAFE0001;
      @(negedge clk);
      chk("lit_fetch_rvalid", f_rvalid, 1);
      chk("lit_fetch_rdata", f_rdata, 32'hCAFE0001);

      // contention, then alternation to fetch
      step();
      f_req = 1'b1; f_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
      @(negedge clk);
      chk("lit_cont_dgnt", {f_gnt, d_gnt, stall_f}, 3'b011);
      chk("lit_cont_addr", mem_addr, 32'h2000);
      step();
      d_req = 1'b0; mem_rdata = 32'h0000BEEF;
      @(negedge clk);
      chk("lit_alt1", {d_rvalid, f_rvalid, f_gnt}, 3'b101);
      chk("lit_alt1_rdata", d_rdata, 32'h0000BEEF);
      step();
      f_req = 1'b0;
      @(negedge clk);
      chk("lit_alt2", {d_rvalid, f_rvalid}, 2'b01);

      // byte store: no response afterwards
      step();
      d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_wdata = 32'hAB; d_addr = 32'h3000;
      @(negedge clk);
      chk("lit_store", {mem_we, mem_byte, d_gnt}, 3'b111);
      chk("lit_store_wdata", mem_wdata, 32'hAB);
      step();
      d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
      @(negedge clk);
      chk("lit_store_norv", d_rvalid, 0);

      // starvation: both held for ten cycles
      step();
      f_req = 1'b1; d_req = 1'b1; d_addr = 32'h4000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         pat[i] = f_gnt;
         step();
      end
      chk("lit_starve_pat", pat, 10'h210);
      f_req = 1'b0; d_req = 1'b0;

      // reset lands while a fetch read is in flight
      step();
      f_req = 1'b1; f_addr = 32'h500;
      @(negedge clk);
      chk("lit_mid_gnt", f_gnt, 1);
      #2 rst = 1'b0;
      step();
      f_req = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("lit_mid_norv", {f_rvalid, d_rvalid}, 2'b00);

      // random traffic obeying hold-until-grant
      fg_prev = 1'b0; dg_prev = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         fg_prev = f_gnt; dg_prev = d_gnt;
         @(posedge clk); #1;
         mem_rdata = $urandom;
         if (!f_req || fg_prev) begin
            f_req  = ($urandom_range(3, 0) != 0);
            f_addr = $urandom;
         end
         if (!d_req || dg_prev) begin
            d_req   = ($urandom_range(3, 0) != 0);
            d_we    = $urandom_range(1, 0);
            d_byte  = $urandom_range(1, 0);
            d_addr  = $urandom;
            d_wdata = $urandom;
         end
      end
      f_req = 1'b0; d_req = 1'b0;
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
